serial_frame_feeder: RTL and testbench
======================================

// Module: serial_frame_feeder
// PURPOSE
//  Parallel-to-serial stage directly upstream of the 10010 sequence detector: drives its serial input.
//  Accepts WIDTH-bit words on a valid/ready handshake and shifts them out one bit per clock.
//  Supports gapless back-to-back streaming and provides a per-bit valid and an end-of-frame pulse.
// PARAMETERS
//  WIDTH     8  data bits per word; legal range >= 2; bit counter width = $clog2(WIDTH+1)
//  MSB_FIRST 1  1: din[WIDTH-1] is sent first; 0: din[0] is sent first
//  IDLE_BIT  0  value driven on sout whenever sout_valid = 0
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  din         in   WIDTH  parallel word; sampled only on handshake
//  din_valid   in   1      upstream word available
//  din_ready   out  1      combinational; block can take a word this cycle
//  sout        out  1      registered serial bit; feeds detector inp
//  sout_valid  out  1      registered; sout carries a frame bit this cycle
//  frame_done  out  1      registered; 1-cycle pulse coincident with the final bit of a frame
//  busy        out  1      registered; 1 while state != IDLE
// BEHAVIOUR
//  - Reset (rst_n = 0, immediate): state = IDLE, shift register = 0, count = 0, parity = 0.
//    Outputs during reset: sout = IDLE_BIT, sout_valid = 0, frame_done = 0, busy = 0, din_ready = 0.
//  - Handshake: a word transfers on a rising edge where din_valid && din_ready. No data is taken otherwise.
//    din_valid may drop without a transfer; there is no stall on the serial side.
//  - States:
//    IDLE : din_ready = 1. On transfer -> SHIFT, load shift register, count = 0.
//    SHIFT: one bit per cycle, ordered by MSB_FIRST; count increments 0..WIDTH-1.
//    PAR  : (PARITY_EN only) one cycle, sout = stored parity bit.
//  - SHIFT transitions:
//    - count < WIDTH-1: stay in SHIFT.
//    - count = WIDTH-1, no parity: -> SHIFT (reload) on transfer, else -> IDLE.
//    - count = WIDTH-1, with parity: -> PAR.
//  - PAR transitions: -> SHIFT on transfer, else -> IDLE.
//  - din_ready: 1 in IDLE; 1 in the final-bit cycle of a frame (SHIFT with count = WIDTH-1 without parity, or PAR); 0 otherwise.
//  - Latency: first bit appears on sout the cycle after the transfer edge.
//    A frame is WIDTH bits (WIDTH+1 with parity). Back-to-back frames have zero idle cycles.
//  - frame_done: asserted exactly on the last data bit (no parity) or on the parity bit; never in IDLE.
//  - Simultaneous events: a reload in the final-bit cycle drops no bits. frame_done for the old frame and
//    sout_valid for the new first bit are on consecutive cycles.
//  - Reset mid-frame aborts the frame: no frame_done is issued and the partial word is discarded.
//    After release, the next word starts from bit 0.
// CONFIGURATION
//  - PARITY_EN defined:
//    - An even-parity bit (XOR of all WIDTH data bits) is computed at transfer and stored.
//    - It is sent as bit WIDTH+1 in state PAR.
//    - din_ready is not asserted on the last data bit.
//  - PARITY_EN undefined: PAR state and the parity register do not exist; frames are WIDTH bits.
// TESTING
//  1. Basic frame: rst_n low 3 cycles, then din = 8'hA5 with one-cycle valid (MSB_FIRST=1).
//     -> sout = 1,0,1,0,0,1,0,1 on cycles +1..+8, sout_valid high 8 cycles, frame_done on +8 only.
//  2. Back-to-back: din_valid held high with 8'h12 then 8'h48.
//     -> 16 contiguous valid bits 00010010_01001000, din_ready high only in IDLE and on bit 8, no gap.
//  3. Detector chain: stream 8'h12 into the 10010 detector.
//     -> detector output pulses exactly once, after the bit sequence 1,0,0,1,0 has been delivered.
//  4. Mid-frame reset: transfer 8'hFF, pull rst_n low during bit 3.
//     -> sout = IDLE_BIT, sout_valid = 0 immediately, no frame_done.
//     -> After release, 8'h81 gives sout 1,0,0,0,0,0,0,1.
//  5. PARITY_EN, din = 8'h07. -> 9 bits 00000111 then 1; frame_done on the 9th bit; din_ready low on bit 8, high on bit 9.
//  6. Idle hold: din_valid = 0 for 20 cycles. -> sout = IDLE_BIT, sout_valid = 0, busy = 0 throughout.

Source files
------------

// File: rtl/serial_frame_feeder.sv
// Parallel-to-serial feeder for the 10010 sequence detector: valid/ready word in, one bit per clock out.
// Optional even-parity bit after each word when PARITY_EN is defined.
module serial_frame_feeder #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_n;
    logic [CW-1:0]    count, count_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             sout_n, sout_valid_n, frame_done_n, busy_n;
    logic             xfer, load;
`ifdef PARITY_EN
    logic             parity, parity_n;
`endif

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Ready only when the current cycle is the last one of a frame (or idle), so reloads are gapless.
`ifdef PARITY_EN
    assign din_ready = rst_n && (state == IDLE || state == PAR);
`else
    assign din_ready = rst_n && (state == IDLE || (state == SHIFT && count == LAST));
`endif
    assign xfer = din_valid && din_ready;

    always_comb begin
        state_n = state;
        count_n = count;
        shreg_n = shreg;
        sout_n  = IDLE_BIT;
        load    = 1'b0;
`ifdef PARITY_EN
        parity_n = parity;
`endif
        case (state)
            IDLE: load = xfer;
            SHIFT: begin
                if (count != LAST) begin
                    count_n = count + CW'(1);
                    sout_n  = first_bit(shreg);
                    shreg_n = shift_word(shreg);
                end else begin
`ifdef PARITY_EN
                    state_n = PAR;
                    sout_n  = parity;
`else
                    if (xfer) load = 1'b1;
                    else      state_n = IDLE;
`endif
                end
            end
`ifdef PARITY_EN
            PAR: begin
                if (xfer) load = 1'b1;
                else      state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase

        // The first bit goes straight into the output register so it appears one cycle after transfer.
        if (load) begin
            state_n = SHIFT;
            count_n = '0;
            sout_n  = first_bit(din);
            shreg_n = shift_word(din);
`ifdef PARITY_EN
            parity_n = ^din;
`endif
        end

        sout_valid_n = (state_n != IDLE);
        busy_n       = (state_n != IDLE);
`ifdef PARITY_EN
        frame_done_n = (state_n == PAR);
`else
        frame_done_n = (state_n == SHIFT) && (count_n == LAST);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            shreg      <= '0;
            sout       <= IDLE_BIT;
            sout_valid <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
`ifdef PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            count      <= count_n;
            shreg      <= shreg_n;
            sout       <= sout_n;
            sout_valid <= sout_valid_n;
            frame_done <= frame_done_n;
            busy       <= busy_n;
`ifdef PARITY_EN
            parity     <= parity_n;
`endif
        end
    end

endmodule

// File: tb/tb_serial_frame_feeder.sv
// Directed bench for serial_frame_feeder with an expected-bit scoreboard and a 10010 detector model.
module tb_serial_frame_feeder;

    localparam int   W        = 8;
    localparam logic IDLE_BIT = 1'b0;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         din_valid = 1'b0;
    logic [W-1:0] din       = '0;
    logic         din_ready, sout, sout_valid, frame_done, busy;

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         hits   = 0;
    logic [4:0] det    = '0;

    always #5 clk = ~clk;

    serial_frame_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_BIT)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sout(sout), .sout_valid(sout_valid), .frame_done(frame_done), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.b = w[W-1-i];
`ifdef PARITY_EN
            e.last = 1'b0;
`else
            e.last = (i == W - 1);
`endif
            exp_q.push_back(e);
        end
`ifdef PARITY_EN
        e.b    = ^w;
        e.last = 1'b1;
        exp_q.push_back(e);
`endif
    endtask

    task automatic send(input logic [W-1:0] w);
        int n;
        n = 0;
        while (!din_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(n < 50), 1);
        din       = w;
        din_valid = 1'b1;
        @(posedge clk);
        push_word(w);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n < 100), 1);
        tick();
    endtask

    // Scoreboard and detector model, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sout_valid) begin
            chk("bit_expected", 32'(exp_q.size() > 0), 1);
            chk("busy_active", busy, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sout_bit", sout, e.b);
                chk("frame_done", frame_done, e.last);
            end
            det = {det[3:0], sout};
            if (det == 5'b10010) hits++;
        end else begin
            chk("idle_sout", sout, IDLE_BIT);
            chk("idle_frame_done", frame_done, 0);
            chk("idle_busy", busy, 0);
            chk("gap_pending_bits", exp_q.size(), 0);
        end
    end

    initial begin
        int n;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sout", sout, IDLE_BIT);
        chk("rst_sout_valid", sout_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_din_ready", din_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_din_ready", din_ready, 1);

        // Basic frame, first bit one cycle after transfer
        send(8'hA5);
        chk("first_valid", sout_valid, 1);
        chk("first_bit", sout, 1);
        wait_idle();

        // Back-to-back with din_valid held high
        din       = 8'h12;
        din_valid = 1'b1;
        @(posedge clk);
        push_word(8'h12);
        #1;
        din = 8'h48;
        n   = 0;
        while (!din_ready && n < 20) begin
            tick();
            n++;
        end
`ifdef PARITY_EN
        chk("b2b_ready_wait", n, W);
`else
        chk("b2b_ready_wait", n, W - 1);
`endif
        @(posedge clk);
        push_word(8'h48);
        #1;
        din_valid = 1'b0;
        wait_idle();

        // Detector chain
        det  = '0;
        hits = 0;
        send(8'h12);
        wait_idle();
        chk("detector_hits", hits, 1);

        // Mid-frame reset
        send(8'hFF);
        repeat (3) tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_sout_valid", sout_valid, 0);
        chk("abort_sout", sout, IDLE_BIT);
        chk("abort_frame_done", frame_done, 0);
        chk("abort_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'h81);
        wait_idle();

        // Last-bit ready behaviour (parity bit when enabled)
        send(8'h07);
        repeat (W - 1) tick();
`ifdef PARITY_EN
        chk("last_data_ready", din_ready, 0);
        tick();
        chk("parity_ready", din_ready, 1);
        chk("parity_bit", sout, 1);
`else
        chk("last_data_ready", din_ready, 1);
`endif
        wait_idle();

        // Idle hold
        din_valid = 1'b0;
        repeat (20) tick();
        chk("hold_din_ready", din_ready, 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
